// File: rtl/sti_dac_gen.sv
// Serial transmitter: formats a parallel word to 1-4 pixels, shifts it out under
// receiver back-pressure and writes each completed pixel group to a pixel buffer.
module sti_dac_gen #(
  parameter int DW    = 16,
  parameter int PW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] pi_data,
  input  logic [1:0]    pi_length,
  input  logic          pi_fill,
  input  logic          pi_msb,
  input  logic          pi_low,
  input  logic          pi_end,
  input  logic          so_ready,
  output logic          busy,
  output logic          so_data,
  output logic          so_valid,
  output logic          pixel_wr,
  output logic [AW-1:0] pixel_addr,
  output logic [PW-1:0] pixel_dataout,
  output logic          pixel_finish,
  output logic          pixel_ovf
);
  localparam int LMAX = 4 * PW;
  localparam int LW   = $clog2(LMAX + 1);
  localparam int PCW  = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {IDLE, SEND, FILL, DONE} state_t;

  state_t          state_reg, state_next;
  logic [LMAX-1:0] sreg_reg, sreg_next;
  logic [LW-1:0]   left_reg, left_next;
  logic [PCW-1:0]  pcnt_reg, pcnt_next;
  logic [PW-1:0]   pix_reg, pix_next;
  logic            end_reg, end_next;
  logic            valid_reg, valid_next;
  logic            wr_reg, wr_next;
  logic [PW-1:0]   wdata_reg, wdata_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic            finish_reg, finish_next;
  logic            ovf_reg, ovf_next;
  logic            wrapped_reg, wrapped_next;

  int              len_i;
  logic [LMAX-1:0] ext, fmt, fmt_rev, load_word;
  logic            consume, group_done, wrap_now;
  logic [PW-1:0]   pix_shift;

  // Formatted word is right-aligned in LMAX bits with zeros above bit L-1.
  always_comb begin
    len_i = (int'(pi_length) + 1) * PW;
    ext   = LMAX'(pi_data);
    if (len_i == DW)
      fmt = ext;
    else if (len_i < DW)
      fmt = pi_low ? (ext >> (DW - len_i)) : (ext & ~({LMAX{1'b1}} << len_i));
    else
      fmt = pi_fill ? (ext << (len_i - DW)) : ext;
  end

  // The next bit to transmit always sits at the top of the shift register.
  genvar gi;
  for (gi = 0; gi < LMAX; gi++) begin : g_rev
    assign fmt_rev[LMAX-1-gi] = fmt[gi];
  end
  assign load_word = pi_msb ? (fmt << (LMAX - len_i)) : fmt_rev;

  assign consume    = valid_reg && so_ready;
  assign group_done = consume && (pcnt_reg == PCW'(PW - 1));
  assign wrap_now   = wr_reg && (addr_reg == AW'(DEPTH - 1));
  assign pix_shift  = (pix_reg << 1) | PW'(sreg_reg[LMAX-1]);

  always_comb begin
    state_next   = state_reg;
    sreg_next    = sreg_reg;
    left_next    = left_reg;
    pcnt_next    = pcnt_reg;
    pix_next     = pix_reg;
    end_next     = end_reg;
    valid_next   = valid_reg;
    wr_next      = 1'b0;
    wdata_next   = '0;
    finish_next  = finish_reg;
    ovf_next     = ovf_reg;
    wrapped_next = wrapped_reg | wrap_now;
    addr_next    = addr_reg;
    if (wr_reg)
      addr_next = wrap_now ? '0 : addr_reg + AW'(1);

    case (state_reg)
      IDLE: begin
        if (load) begin
          sreg_next  = load_word;
          left_next  = LW'(len_i);
          pcnt_next  = '0;
          end_next   = pi_end;
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (consume) begin
          sreg_next = sreg_reg << 1;
          pix_next  = pix_shift;
          left_next = left_reg - LW'(1);
          pcnt_next = group_done ? '0 : pcnt_reg + PCW'(1);
          if (group_done) begin
            wr_next    = 1'b1;
            wdata_next = pix_shift;
            if (wrapped_reg || wrap_now)
              ovf_next = 1'b1;
          end
          if (left_reg == LW'(1)) begin
            valid_next = 1'b0;
            state_next = end_reg ? FILL : IDLE;
          end
        end
      end
      FILL: begin
        // Every FILL cycle carries a write; stop once it targets the last address.
        if (wrap_now) begin
          finish_next = 1'b1;
          state_next  = DONE;
        end else begin
          wr_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      sreg_reg    <= '0;
      left_reg    <= '0;
      pcnt_reg    <= '0;
      pix_reg     <= '0;
      end_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      wr_reg      <= 1'b0;
      wdata_reg   <= '0;
      addr_reg    <= '0;
      finish_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
      wrapped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sreg_reg    <= sreg_next;
      left_reg    <= left_next;
      pcnt_reg    <= pcnt_next;
      pix_reg     <= pix_next;
      end_reg     <= end_next;
      valid_reg   <= valid_next;
      wr_reg      <= wr_next;
      wdata_reg   <= wdata_next;
      addr_reg    <= addr_next;
      finish_reg  <= finish_next;
      ovf_reg     <= ovf_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign busy          = (state_reg != IDLE);
  assign so_data       = sreg_reg[LMAX-1];
  assign so_valid      = valid_reg;
  assign pixel_wr      = wr_reg;
  assign pixel_addr    = addr_reg;
  assign pixel_dataout = wdata_reg;
  assign pixel_finish  = finish_reg;
  assign pixel_ovf     = ovf_reg;
endmodule

// File: doc/sti_dac_gen.md
Name: sti_dac_gen

Overview:
Parametrised serial transmitter and data-arrangement controller. It accepts one parallel word per load handshake and re-formats it to a selectable length of 1–4 pixels (slice, or zero-fill). The word is shifted out serially under receiver back-pressure, and each completed pixel-width group is written to a pixel buffer. On the final word it zero-fills the rest of the pixel buffer, then raises a finish flag. It sits between the host word interface and the serial link / pixel RAM.

Parameters:
DW, 16, input data width; constraint PW <= DW <= 4*PW.
PW, 8, pixel width in bits; serial length unit.
AW, 8, pixel address width.
DEPTH, 256, pixel buffer depth; constraint DEPTH <= 2**AW.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
load  in  1  word-valid strobe; sampled only when busy=0.
pi_data  in  DW  parallel word.
pi_length  in  2  output length L = (pi_length+1)*PW bits.
pi_fill  in  1  L>DW: 1 = data MSB-aligned with zeros below; 0 = zeros above.
pi_msb  in  1  1 = transmit MSB first; 0 = LSB first.
pi_low  in  1  L<DW: 1 = use upper L bits of pi_data; 0 = lower L bits.
pi_end  in  1  last word; sampled with load.
so_ready  in  1  serial receiver ready.
busy  out  1  high in every state except IDLE.
so_data  out  1  serial bit, registered.
so_valid  out  1  so_data valid, registered.
pixel_wr  out  1  one-cycle pixel write strobe.
pixel_addr  out  AW  pixel write address.
pixel_dataout  out  PW  pixel data; 0 when pixel_wr=0.
pixel_finish  out  1  sticky completion flag.
pixel_ovf  out  1  sticky: a data pixel was written at address DEPTH-1 and further data arrived.

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, pixel_addr 0. A reset in any state aborts at once; partial words are discarded.
- States: IDLE, SEND, FILL, DONE.
- IDLE: load=1 latches the formatted word (L bits) and pi_end into the shift register, then goes to SEND. so_valid=1 with the first bit on the next cycle.
- Formatting: L==DW uses the word as is. L<DW takes the slice chosen by pi_low. L>DW pads per pi_fill.
- SEND: a bit is consumed on each cycle with so_valid&&so_ready. While so_ready=0, so_data and so_valid are held and nothing advances.
- Pixel groups: each PW consumed bits form one pixel, and the first-transmitted bit becomes pixel MSB.
  - pixel_wr=1 and pixel_dataout=group in the cycle after the group's last bit is consumed.
  - pixel_addr holds the write address during that cycle and increments by 1 afterwards.
- pixel_addr wraps to 0 past DEPTH-1. If a data write then occurs, pixel_ovf is set.
- After the L-th bit is consumed, so_valid drops the next cycle.
  - pi_end=0: go to IDLE. busy is low for at least 1 cycle before the next load is taken.
  - pi_end=1: go to FILL.
  - load while busy=1 is ignored, with no error.
- FILL: writes one zero pixel per cycle (pixel_wr=1, pixel_dataout=0) to addresses from the next free address through DEPTH-1.
  - The first fill write is the cycle after the last data write.
  - If the last data write hit DEPTH-1, go straight to DONE.
- DONE: pixel_finish=1 from the cycle after the final write and held until reset. load is ignored and busy=1.
- pixel_wr never asserts on two pixels in the same cycle. Back-pressure only stretches the gaps between writes.

Test Plan:
1. DW=16/PW=8, pi_length=1, pi_msb=1, pi_data=16'hA5C3, so_ready=1 -> serial 1010010111000011 over 16 cycles; writes A5@0, C3@1; busy low after.
2. pi_length=0, pi_low=1, pi_msb=0, pi_data=16'h12F0 -> serial 0,1,0,0,1,0,0,0; one write 8'h48@0.
3. pi_length=3, pi_fill=1, pi_msb=1, pi_data=16'hBEEF -> writes BE,EF,00,00. Repeat with pi_fill=0, pi_msb=0 -> writes F7,7D,00,00.
4. Case 1 with so_ready=0 for 3 cycles after bit 5 -> so_data held; no bit lost or duplicated; A5 write delayed exactly 3 cycles.
5. Word with pi_end=1 whose last pixel lands at address 3 -> zero writes at 4..255 on consecutive cycles; pixel_finish=1 the cycle after addr 255; a later load is ignored.
6. reset asserted mid-SEND (bit 9 of case 1) -> all outputs 0 immediately. A fresh load after release restarts at pixel_addr 0.
